// File: rtl/core_run_sequencer.sv
// core_run_sequencer
// Bring-up and run controller for CoreTop. It drives the ClockGate enable and
// the core reset, fires a one-shot first-fetch trigger, supervises the run
// with a kickable watchdog and, after the core halts, keeps the clock on for a
// drain window so that in-flight stores can retire.
//
// Ports
//   clk                  free-running platform clock
//   rst                  synchronous active-high reset
//   start                begin a bring-up sequence (accepted in IDLE or FAULT)
//   abort                force a return to IDLE from any state
//   boot_addr            first fetch address, captured on an accepted start
//   core_halt            core reached end of program (level or pulse)
//   wd_kick              core progress indication, reloads the watchdog
//   cg_clk_en            enable to ClockGate
//   core_rstn            CoreTop reset, active low
//   first_fetch_trigger  one-cycle pulse to CoreTop
//   first_fetch_addr     captured boot_addr
//   busy                 high in every state except IDLE and FAULT
//   done                 one-cycle pulse on normal completion
//   timeout              watchdog fault flag, held while in FAULT
//   run_cycles           cycles spent in RUN, saturating
//
// All outputs are registered. They are decoded from the next state so that
// the value seen on an output matches the state the FSM currently occupies.

module core_run_sequencer #(
  parameter int unsigned RST_CYCLES      = 10,
  parameter int unsigned SETTLE_CYCLES   = 10,
  parameter int unsigned WATCHDOG_CYCLES = 200,
  parameter int unsigned DRAIN_CYCLES    = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic              core_halt,
  input  logic              wd_kick,
  output logic              cg_clk_en,
  output logic              core_rstn,
  output logic              first_fetch_trigger,
  output logic [ADDR_W-1:0] first_fetch_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       run_cycles
);

  // One down-counter is shared by every timed state, so it is sized for the
  // longest of the four intervals.
  localparam int unsigned MaxRs  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxWd  = (WATCHDOG_CYCLES > DRAIN_CYCLES) ? WATCHDOG_CYCLES
                                                                    : DRAIN_CYCLES;
  localparam int unsigned MaxCyc = (MaxRs > MaxWd) ? MaxRs : MaxWd;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  // A state lasting N cycles is entered with N-1 and exits on the cycle where
  // the counter reads zero.
  localparam logic [CntW-1:0] RstLoad    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] WdLoad     = CntW'(WATCHDOG_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLoad  = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StSettle,
    StTrigger,
    StRun,
    StDrain,
    StStop,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       run_q, run_d;

  logic cg_clk_en_q, cg_clk_en_d;
  logic core_rstn_q, core_rstn_d;
  logic trig_q, trig_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;

  // Next-state, counter, address capture and run-cycle accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    run_d   = run_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StReset;
          cnt_d   = RstLoad;
          addr_d  = boot_addr;
          run_d   = '0;
        end
      end

      StReset: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StTrigger;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StTrigger: begin
        state_d = StRun;
        cnt_d   = WdLoad;
      end

      StRun: begin
        if (run_q != '1) begin
          run_d = run_q + 32'd1;
        end
        // Halt beats a kick, and a kick beats expiry in the same cycle.
        if (core_halt) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end else if (wd_kick) begin
          cnt_d = WdLoad;
        end else if (cnt_q == '0) begin
          state_d = StFault;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StStop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StStop: begin
        state_d = StIdle;
        cnt_d   = '0;
      end

      StFault: begin
        if (start && !abort) begin
          state_d = StReset;
          cnt_d   = RstLoad;
          addr_d  = boot_addr;
          run_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Abort wins over everything else and drops straight to IDLE.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // Output decode from the state being entered.
  always_comb begin
    cg_clk_en_d = 1'b0;
    core_rstn_d = 1'b0;
    trig_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    case (state_d)
      StIdle: begin
        cg_clk_en_d = 1'b0;
        core_rstn_d = 1'b0;
      end
      StReset: begin
        cg_clk_en_d = 1'b1;
        core_rstn_d = 1'b0;
        busy_d      = 1'b1;
      end
      StSettle: begin
        cg_clk_en_d = 1'b1;
        core_rstn_d = 1'b1;
        busy_d      = 1'b1;
      end
      StTrigger: begin
        cg_clk_en_d = 1'b1;
        core_rstn_d = 1'b1;
        trig_d      = 1'b1;
        busy_d      = 1'b1;
      end
      StRun, StDrain: begin
        cg_clk_en_d = 1'b1;
        core_rstn_d = 1'b1;
        busy_d      = 1'b1;
      end
      StStop: begin
        // Clock stops but reset stays released so the core state can be dumped.
        cg_clk_en_d = 1'b0;
        core_rstn_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b1;
      end
      StFault: begin
        cg_clk_en_d = 1'b0;
        core_rstn_d = 1'b1;
        timeout_d   = 1'b1;
      end
      default: begin
        cg_clk_en_d = 1'b0;
        core_rstn_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      run_q       <= '0;
      cg_clk_en_q <= 1'b0;
      core_rstn_q <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      run_q       <= run_d;
      cg_clk_en_q <= cg_clk_en_d;
      core_rstn_q <= core_rstn_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cg_clk_en           = cg_clk_en_q;
  assign core_rstn           = core_rstn_q;
  assign first_fetch_trigger = trig_q;
  assign first_fetch_addr    = addr_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout             = timeout_q;
  assign run_cycles          = run_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Testbench for core_run_sequencer with RST=4, SETTLE=3, WATCHDOG=20, DRAIN=5.
// Stimulus pushes expected per-cycle snapshots and expected pulse cycles into
// queues; a monitor on the falling edge pops and compares them.

module tb_core_run_sequencer;

  localparam int unsigned RstC = 4;
  localparam int unsigned SetC = 3;
  localparam int unsigned WdC  = 20;
  localparam int unsigned DrC  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] boot_addr;
  logic        core_halt;
  logic        wd_kick;
  logic        cg_clk_en;
  logic        core_rstn;
  logic        first_fetch_trigger;
  logic [15:0] first_fetch_addr;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;

  core_run_sequencer #(
    .RST_CYCLES     (RstC),
    .SETTLE_CYCLES  (SetC),
    .WATCHDOG_CYCLES(WdC),
    .DRAIN_CYCLES   (DrC),
    .ADDR_W         (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .boot_addr          (boot_addr),
    .core_halt          (core_halt),
    .wd_kick            (wd_kick),
    .cg_clk_en          (cg_clk_en),
    .core_rstn          (core_rstn),
    .first_fetch_trigger(first_fetch_trigger),
    .first_fetch_addr   (first_fetch_addr),
    .busy               (busy),
    .done               (done),
    .timeout            (timeout),
    .run_cycles         (run_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef enum int {EIdle, EReset, ESettle, ETrig, ERun, EDrain, EStop, EFault} est_e;

  typedef struct {
    int          cyc;
    string       tag;
    est_e        st;
    logic [15:0] addr;
    bit          chk_addr;
    logic [31:0] run;
    bit          chk_run;
  } exp_t;

  exp_t  exp_q[$];
  int    trig_q[$];
  int    done_q[$];
  string scen = "none";

  // {cg_clk_en, core_rstn, first_fetch_trigger, busy, done, timeout}
  function automatic logic [5:0] flags_of(est_e s);
    case (s)
      EIdle:   return 6'b000000;
      EReset:  return 6'b100100;
      ESettle: return 6'b110100;
      ETrig:   return 6'b111100;
      ERun:    return 6'b110100;
      EDrain:  return 6'b110100;
      EStop:   return 6'b010110;
      EFault:  return 6'b010001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic void exp_at(int c, est_e s, logic [15:0] a, bit ca, logic [31:0] r, bit cr);
    exp_t e;
    e.cyc      = c;
    e.tag      = scen;
    e.st       = s;
    e.addr     = a;
    e.chk_addr = ca;
    e.run      = r;
    e.chk_run  = cr;
    exp_q.push_back(e);
    if (s == ETrig) trig_q.push_back(c);
    if (s == EStop) done_q.push_back(c);
  endfunction

  // Monitor
  exp_t       m_e;
  bit         m_ok;
  logic [5:0] m_got;

  always @(negedge clk) begin
    m_got = {cg_clk_en, core_rstn, first_fetch_trigger, busy, done, timeout};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        m_e = exp_q[i];
        exp_q.delete(i);
        n_checks++;
        m_ok = (m_e.cyc == cyc) && (m_got === flags_of(m_e.st)) &&
               (!m_e.chk_addr || (first_fetch_addr === m_e.addr)) &&
               (!m_e.chk_run || (run_cycles === m_e.run));
        if (m_ok) begin
          n_pass++;
        end else begin
          $display("FAIL %s/%s cyc=%0d: got flags=%b addr=%h run=%0d, required flags=%b addr=%h run=%0d",
                   m_e.tag, m_e.st.name(), cyc, m_got, first_fetch_addr, run_cycles,
                   flags_of(m_e.st), m_e.addr, m_e.run);
        end
      end
    end

    if (trig_q.size() != 0 && trig_q[0] < cyc) begin
      n_checks++;
      $display("FAIL trig_missing: no trigger pulse, required at cyc=%0d", trig_q[0]);
      void'(trig_q.pop_front());
    end
    if (first_fetch_trigger === 1'b1) begin
      n_checks++;
      if (trig_q.size() != 0 && trig_q[0] == cyc) begin
        n_pass++;
        void'(trig_q.pop_front());
      end else begin
        $display("FAIL trig_unexpected: pulse at cyc=%0d, required none", cyc);
      end
    end

    if (done_q.size() != 0 && done_q[0] < cyc) begin
      n_checks++;
      $display("FAIL done_missing: no done pulse, required at cyc=%0d", done_q[0]);
      void'(done_q.pop_front());
    end
    if (done === 1'b1) begin
      n_checks++;
      if (done_q.size() != 0 && done_q[0] == cyc) begin
        n_pass++;
        void'(done_q.pop_front());
      end else begin
        $display("FAIL done_unexpected: pulse at cyc=%0d, required none", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    core_halt = 1'b0;
    wd_kick   = 1'b0;
  endtask

  // Start in the current cycle and expect states for the next `upto` cycles.
  task automatic begin_seq(input logic [15:0] a, input int upto, input bit hold_start);
    int   c0;
    est_e s;
    c0        = cyc;
    boot_addr = a;
    start     = 1'b1;
    for (int o = 1; o <= upto; o++) begin
      if (o <= int'(RstC)) s = EReset;
      else if (o <= int'(RstC + SetC)) s = ESettle;
      else if (o == int'(RstC + SetC + 1)) s = ETrig;
      else s = ERun;
      exp_at(c0 + o, s, a, 1'b1, 32'd0, 1'b1);
    end
    for (int o = 1; o <= upto; o++) begin
      step();
      if (!hold_start) start = 1'b0;
      boot_addr = ~a;
    end
  endtask

  // Called in the TRIGGER cycle; returns in the first cycle after RUN cycle n.
  task automatic run_phase(input logic [15:0] a, input int n, input int kick_every,
                           input int kick_at, input int halt_at);
    for (int k = 1; k <= n; k++) begin
      step();
      wd_kick   = ((kick_every > 0) && (k % kick_every == 0)) || (k == kick_at);
      core_halt = (k == halt_at);
      exp_at(cyc, ERun, a, 1'b1, 32'(k - 1), 1'b1);
    end
    step();
    idle_inputs();
  endtask

  // Called in the first DRAIN cycle; returns in the IDLE cycle after STOP.
  task automatic drain_stop(input logic [15:0] a, input logic [31:0] r);
    int c;
    c = cyc;
    for (int d = 0; d < int'(DrC); d++) exp_at(c + d, EDrain, a, 1'b1, r, 1'b1);
    exp_at(c + int'(DrC), EStop, a, 1'b1, r, 1'b1);
    exp_at(c + int'(DrC) + 1, EIdle, a, 1'b0, r, 1'b1);
    repeat (DrC + 1) step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    rst       = 1'b1;
    boot_addr = 16'h0;
    idle_inputs();

    scen = "reset";
    for (int i = 1; i <= 4; i++) exp_at(i, EIdle, 16'h0, 1'b1, 32'd0, 1'b1);
    repeat (3) step();
    rst = 1'b0;
    step();

    scen = "normal";
    begin_seq(16'h0040, 8, 1'b0);
    run_phase(16'h0040, 30, 5, 0, 30);
    drain_stop(16'h0040, 32'd30);

    scen = "watchdog";
    begin_seq(16'h1234, 8, 1'b0);
    run_phase(16'h1234, int'(WdC), 0, 0, 0);
    c = cyc;
    for (int i = 0; i < 3; i++) exp_at(c + i, EFault, 16'h1234, 1'b1, 32'd20, 1'b1);
    repeat (2) step();

    scen = "recover";
    begin_seq(16'h0040, 8, 1'b0);
    scen = "boundary";
    run_phase(16'h0040, 40, 0, 20, 40);
    drain_stop(16'h0040, 32'd40);

    scen = "abort_settle";
    begin_seq(16'hbeef, 6, 1'b0);
    abort = 1'b1;
    c = cyc;
    exp_at(c + 1, EIdle, 16'h0, 1'b0, 32'd0, 1'b0);
    step();
    scen  = "start_abort_idle";
    start = 1'b1;
    abort = 1'b1;
    exp_at(c + 2, EIdle, 16'h0, 1'b0, 32'd0, 1'b0);
    step();
    idle_inputs();
    exp_at(c + 3, EIdle, 16'h0, 1'b0, 32'd0, 1'b0);
    step();

    scen = "abort_drain";
    begin_seq(16'h0a0a, 8, 1'b0);
    run_phase(16'h0a0a, 3, 0, 0, 3);
    c = cyc;
    exp_at(c, EDrain, 16'h0a0a, 1'b1, 32'd3, 1'b1);
    exp_at(c + 1, EDrain, 16'h0a0a, 1'b1, 32'd3, 1'b1);
    exp_at(c + 2, EIdle, 16'h0, 1'b0, 32'd0, 1'b0);
    exp_at(c + 3, EIdle, 16'h0, 1'b0, 32'd0, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    scen = "rst_run";
    begin_seq(16'h5555, 8, 1'b1);
    start = 1'b0;
    run_phase(16'h5555, 4, 0, 0, 0);
    c = cyc;
    exp_at(c, ERun, 16'h5555, 1'b1, 32'd4, 1'b1);
    exp_at(c + 1, EIdle, 16'h0, 1'b1, 32'd0, 1'b1);
    exp_at(c + 2, EIdle, 16'h0, 1'b1, 32'd0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();

    n_checks++;
    if (exp_q.size() == 0 && trig_q.size() == 0 && done_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL leftover: pending exp=%0d trig=%0d done=%0d, required 0/0/0",
               exp_q.size(), trig_q.size(), done_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
